data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dm_pkg.sv | 42 ++++
 rtl/dm_ram.sv | 37 +++
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : dm_pkg                                                 |
// | Brief   : Shared types, defaults and preload table for data_mem  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dm_pkg;

  localparam int DM_DW        = 16;
  localparam int DM_DEPTH     = 256;
  localparam int DM_PRELOAD_N = 5;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } dm_state_e;

  function automatic logic [15:0] dm_preload_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'd0;
      3'd1:    return 16'd2;
      3'd2:    return 16'd4;
      3'd3:    return 16'd6;
      3'd4:    return 16'd8;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [7:0] dm_preload_val(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'd100;
      3'd1:    return 8'd43;
      3'd2:    return 8'd6;
      3'd3:    return 8'd58;
      3'd4:    return 8'd77;
      default: return 8'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : dm_ram                                                 |
// | Brief   : Single-port RAM, byte-enable write, registered read    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dm_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    // Read register only moves on a read so the last read value is held.
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : data_mem_ctrl                                          |
// | Brief   : Clear/preload init FSM plus 1-cycle request port       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int DW         = DM_DW,
  parameter int DEPTH      = DM_DEPTH,
  parameter int PRELOAD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [15:0]     req_addr,
  input  logic [DW/8-1:0] req_be,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            init_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dm_state_e state_q, state_d;
  logic [16:0] cnt_q, cnt_d;

  logic            accept;
  logic            in_range;
  logic [15:0]     pl_addr;
  logic [7:0]      pl_val;
  logic            ram_we, ram_re;
  logic [DW/8-1:0] ram_be;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata, ram_rdata;
  logic            rsp_valid_q, rsp_err_q, rsp_rd_q;

  assign init_busy = (state_q != ST_RUN);
  assign req_ready = (state_q == ST_RUN);
  assign accept    = req_valid & req_ready;
  assign in_range  = ({1'b0, req_addr} < 17'(DEPTH));
  assign pl_addr   = dm_preload_addr(cnt_q[2:0]);
  assign pl_val    = dm_preload_val(cnt_q[2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == 17'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = (PRELOAD_EN != 0) ? ST_LOAD : ST_RUN;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == 17'(DM_PRELOAD_N - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Init engine owns the RAM port until RUN; then the request port does.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_be   = '1;
        ram_addr = cnt_q[AW-1:0];
      end
      ST_LOAD: begin
        ram_we    = ({1'b0, pl_addr} < 17'(DEPTH));
        ram_be    = '1;
        ram_addr  = pl_addr[AW-1:0];
        ram_wdata = DW'(pl_val);
      end
      default: begin
        ram_we    = accept & req_wen & in_range;
        ram_re    = accept & ~req_wen & in_range;
        ram_be    = req_be;
        ram_addr  = req_addr[AW-1:0];
        ram_wdata = req_wdata;
      end
    endcase
  end

  dm_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q <= ~in_range;
        rsp_rd_q  <= ~req_wen & in_range;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_data_mem_ctrl                                       |
// | Brief   : Directed self-checking bench for data_mem_ctrl         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [15:0] req_addr = '0;
  logic [1:0]  req_be = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_ctrl #(.DW(16), .DEPTH(256), .PRELOAD_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // Drive one request for one cycle and sample its response on the next negedge.
  task automatic xact(input logic wen, input logic [15:0] addr, input logic [1:0] be,
                      input logic [15:0] wd, output logic rv, output logic [15:0] rd,
                      output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_be = be; req_wdata = wd;
    @(negedge clk);
    rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
    req_valid = 1'b0; req_wen = 1'b0;
  endtask

  // Count rising edges until init_busy falls; bounded.
  task automatic count_busy(input string name);
    int cyc = 0;
    bit done = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (!init_busy) done = 1;
    end
    n_cmp++;
    if (cyc !== 261) begin
      n_bad++;
      $display("FAIL %s busy_cycles actual=%0d required=261", name, cyc);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_at_busy_fall actual=%b required=1", name, req_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({init_busy, req_ready, rsp_valid, rsp_err} !== 4'b1000 || rsp_rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state actual busy/rdy/vld/err=%b%b%b%b rdata=%h required 1000 rdata=0000",
               init_busy, req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst = 1'b0;
    count_busy("reset_init");
  endtask

  task automatic test_preload;
    logic [15:0] addrs [7] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd1, 16'd255};
    logic [15:0] exps  [7] = '{16'd100, 16'd43, 16'd6, 16'd58, 16'd77, 16'd0, 16'd0};
    logic rv, er;
    logic [15:0] rd;
    for (int i = 0; i < 7; i++) begin
      xact(1'b0, addrs[i], 2'b00, 16'h0, rv, rd, er);
      n_cmp++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== exps[i]) begin
        n_bad++;
        $display("FAIL preload_read addr=%0d actual vld=%b err=%b rdata=%0d required vld=1 err=0 rdata=%0d",
                 addrs[i], rv, er, rd, exps[i]);
      end
    end
    // Idle cycle: strobe drops, data held.
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'd0) begin
      n_bad++;
      $display("FAIL idle_hold actual vld=%b rdata=%h required vld=0 rdata=0000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_byte_enable;
    logic rv, er;
    logic [15:0] rd;
    xact(1'b1, 16'd3, 2'b10, 16'hABCD, rv, rd, er);
    n_cmp++;
    if (rv !== 1'b1 || er !== 1'b0 || rd !== 16'h0) begin
      n_bad++;
      $display("FAIL be_write_rsp actual vld=%b err=%b rdata=%h required 1 0 0000", rv, er, rd);
    end
    xact(1'b0, 16'd3, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (rd !== 16'hAB00) begin
      n_bad++;
      $display("FAIL be_hi_read actual=%h required=ab00", rd);
    end
    xact(1'b1, 16'd3, 2'b01, 16'h1234, rv, rd, er);
    xact(1'b0, 16'd3, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (rd !== 16'hAB34) begin
      n_bad++;
      $display("FAIL be_lo_read actual=%h required=ab34", rd);
    end
    // All-zero enables: response still produced, memory untouched.
    xact(1'b1, 16'd3, 2'b00, 16'hFFFF, rv, rd, er);
    n_cmp++;
    if (rv !== 1'b1 || rd !== 16'h0) begin
      n_bad++;
      $display("FAIL be_zero_rsp actual vld=%b rdata=%h required vld=1 rdata=0000", rv, rd);
    end
    xact(1'b0, 16'd3, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (rd !== 16'hAB34) begin
      n_bad++;
      $display("FAIL be_zero_read actual=%h required=ab34", rd);
    end
  endtask

  task automatic test_out_of_range;
    logic rv, er;
    logic [15:0] rd;
    xact(1'b1, 16'h0100, 2'b11, 16'hFFFF, rv, rd, er);
    n_cmp++;
    if (rv !== 1'b1 || er !== 1'b1 || rd !== 16'h0) begin
      n_bad++;
      $display("FAIL oor_write actual vld=%b err=%b rdata=%h required 1 1 0000", rv, er, rd);
    end
    xact(1'b0, 16'h0100, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (rv !== 1'b1 || er !== 1'b1 || rd !== 16'h0) begin
      n_bad++;
      $display("FAIL oor_read actual vld=%b err=%b rdata=%h required 1 1 0000", rv, er, rd);
    end
    xact(1'b0, 16'hFFFF, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (er !== 1'b1 || rd !== 16'h0) begin
      n_bad++;
      $display("FAIL oor_read_ffff actual err=%b rdata=%h required 1 0000", er, rd);
    end
    xact(1'b0, 16'h0000, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (er !== 1'b0 || rd !== 16'd100) begin
      n_bad++;
      $display("FAIL oor_no_alias actual err=%b rdata=%0d required err=0 rdata=100", er, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic        exp_rd [23];
    logic [15:0] exp_d  [23];
    // 10 writes, 10 reads, write 20 then immediate read 20, then drain.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp_d[i-1]) begin
          n_bad++;
          $display("FAIL stream_rsp idx=%0d actual vld=%b err=%b rdata=%0d required vld=1 err=0 rdata=%0d",
                   i - 1, rsp_valid, rsp_err, rsp_rdata, exp_d[i-1]);
        end
      end
      if (i == 22) begin
        req_valid = 1'b0;
        req_wen   = 1'b0;
      end else begin
        req_valid = 1'b1;
        req_be    = 2'b11;
        if (i < 10) begin
          req_wen = 1'b1; req_addr = 16'(10 + i); req_wdata = 16'((10 + i) * 3);
          exp_d[i] = 16'h0;
        end else if (i < 20) begin
          req_wen = 1'b0; req_addr = 16'(i); req_wdata = 16'h0;
          exp_d[i] = 16'(i * 3);
        end else if (i == 20) begin
          req_wen = 1'b1; req_addr = 16'd20; req_wdata = 16'h0777;
          exp_d[i] = 16'h0;
        end else begin
          req_wen = 1'b0; req_addr = 16'd20; req_wdata = 16'h0;
          exp_d[i] = 16'h0777;
        end
        exp_rd[i] = ~req_wen;
      end
    end
    n_cmp++;
    if (exp_rd[21] !== 1'b1 || rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_last_valid actual=%b required=1", rsp_valid);
    end
  endtask

  task automatic test_reset_midload;
    logic rv, er;
    logic [15:0] rd;
    xact(1'b1, 16'd1, 2'b11, 16'h5555, rv, rd, er);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (258) @(negedge clk);
    n_cmp++;
    if (init_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midload_busy actual=%b required=1", init_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (init_busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midload_reset actual busy=%b rdy=%b vld=%b required 1 0 0", init_busy, req_ready, rsp_valid);
    end
    count_busy("midload_init");
    xact(1'b0, 16'd1, 2'b00, 16'h0, rv, rd, er);
    n_cmp++;
    if (rd !== 16'd0) begin
      n_bad++;
      $display("FAIL midload_cleared actual=%h required=0000", rd);
    end
    test_preload();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
